// File: rtl/hazard_stall_unit.sv
// Pipeline freeze/bubble control: load-use hazard detection, memory-wait hold with
// a watchdog timeout, and a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int unsigned REG_AW  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rest,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_freeze,
    output logic              ifid_freeze,
    output logic              idex_freeze,
    output logic              exmem_freeze,
    output logic              idex_bubble,
    output logic              mem_timeout,
    output logic [15:0]       stall_count,
    output logic              fsm_state
);

    localparam int unsigned WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt, wait_cnt_nx;
    logic           set_timeout;
    logic           hazard;
    logic           wd_fire;
    logic           mem_stall;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (pc_freeze && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    always_comb begin
        hazard = ex_mem_read && (ex_rt != '0) &&
                 ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
        wd_fire   = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST) && !mem_ready;
        mem_stall = ((state == RUN) && mem_req && !mem_ready) ||
                    ((state == MEM_WAIT) && !mem_ready && !wd_fire);

        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        set_timeout = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wd_fire) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                    set_timeout = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WCW'(1);
                end
            end
            default: begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end
        endcase

        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        idex_freeze  = 1'b0;
        exmem_freeze = 1'b0;
        idex_bubble  = 1'b0;
        // Controls are gated by reset so they drop asynchronously, even if inputs still request a stall.
        if (rest) begin
            if (mem_stall) begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                idex_freeze  = 1'b1;
                exmem_freeze = 1'b1;
            end else if (hazard) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with hand-computed expectations.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rest;
    logic [15:0] id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, mem_req, mem_ready;
    logic        pc_freeze, ifid_freeze, idex_freeze, exmem_freeze, idex_bubble;
    logic        mem_timeout, fsm_state;
    logic [15:0] stall_count;

    int passed = 0;
    int total  = 0;

    // {pc, ifid, idex, exmem, bubble}
    wire [4:0] outs = {pc_freeze, ifid_freeze, idex_freeze, exmem_freeze, idex_bubble};

    hazard_stall_unit #(.REG_AW(16), .TIMEOUT(64)) dut (
        .clk(clk), .rest(rest),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .idex_freeze(idex_freeze),
        .exmem_freeze(exmem_freeze), .idex_bubble(idex_bubble),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rest = 1'b0;
        #12 rest = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== 5'b11110) $display("FAIL reset_pre_stall outs=%b want=11110", outs);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (fsm_state !== 1'b1 || stall_count !== 16'd1)
            $display("FAIL reset_pre_wait fsm=%b cnt=%0d want fsm=1 cnt=1", fsm_state, stall_count);
        else passed++;
        #2 rest = 1'b0;
        #1;
        total++;
        if (outs !== 5'b00000) $display("FAIL reset_outs outs=%b want=00000", outs);
        else passed++;
        total++;
        if (fsm_state !== 1'b0 || stall_count !== 16'd0 || mem_timeout !== 1'b0)
            $display("FAIL reset_state fsm=%b cnt=%0d to=%b want 0/0/0", fsm_state, stall_count, mem_timeout);
        else passed++;
        clear_inputs();
        @(negedge clk) rest = 1'b1;
    endtask

    task automatic test_load_use();
        @(posedge clk); #1;
        ex_mem_read = 1'b1; ex_rt = 16'd5; id_rs = 16'd5; id_uses_rs = 1'b1;
        #1;
        total++;
        if (outs !== 5'b11001) $display("FAIL load_use_rs outs=%b want=11001", outs);
        else passed++;
        @(posedge clk); #1;
        ex_rt = 16'd0; id_rs = 16'd0;
        #1;
        total++;
        if (stall_count !== 16'd1) $display("FAIL load_use_count cnt=%0d want=1", stall_count);
        else passed++;
        total++;
        if (outs !== 5'b00000) $display("FAIL load_use_reg0 outs=%b want=00000", outs);
        else passed++;
        ex_rt = 16'd5; id_rs = 16'd5; id_uses_rs = 1'b0;
        #1;
        total++;
        if (outs !== 5'b00000) $display("FAIL load_use_nouse outs=%b want=00000", outs);
        else passed++;
        ex_mem_read = 1'b1; ex_rt = 16'd7; id_rt = 16'd7; id_uses_rt = 1'b1;
        #1;
        total++;
        if (outs !== 5'b11001) $display("FAIL load_use_rt outs=%b want=11001", outs);
        else passed++;
        @(posedge clk); #1;
        clear_inputs();
        #1;
        total++;
        if (stall_count !== 16'd2 || outs !== 5'b00000)
            $display("FAIL load_use_single cnt=%0d outs=%b want cnt=2 outs=00000", stall_count, outs);
        else passed++;
    endtask

    task automatic test_mem_wait();
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== 5'b11110 || fsm_state !== 1'b0)
            $display("FAIL mem_wait_c1 outs=%b fsm=%b want 11110/0", outs, fsm_state);
        else passed++;
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk); #1;
            mem_req = 1'b0;
            #1;
            total++;
            if (outs !== 5'b11110 || fsm_state !== 1'b1)
                $display("FAIL mem_wait_c%0d outs=%b fsm=%b want 11110/1", c, outs, fsm_state);
            else passed++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== 5'b00000) $display("FAIL mem_wait_release outs=%b want=00000", outs);
        else passed++;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        total++;
        if (fsm_state !== 1'b0 || stall_count !== 16'd5)
            $display("FAIL mem_wait_after fsm=%b cnt=%0d want 0/5", fsm_state, stall_count);
        else passed++;
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        ex_mem_read = 1'b1; ex_rt = 16'd3; id_rt = 16'd3; id_uses_rt = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== 5'b11110) $display("FAIL prio_frozen1 outs=%b want=11110", outs);
        else passed++;
        @(posedge clk); #1;
        mem_req = 1'b0;
        #1;
        total++;
        if (outs !== 5'b11110) $display("FAIL prio_frozen2 outs=%b want=11110", outs);
        else passed++;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (outs !== 5'b11001) $display("FAIL prio_release outs=%b want=11001", outs);
        else passed++;
        @(posedge clk); #1;
        clear_inputs();
        #1;
        total++;
        if (fsm_state !== 1'b0 || stall_count !== 16'd8)
            $display("FAIL prio_after fsm=%b cnt=%0d want 0/8", fsm_state, stall_count);
        else passed++;
    endtask

    task automatic test_watchdog();
        int bad = 0;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 63; c++) begin
            #1;
            if (outs !== 5'b11110 || mem_timeout !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        total++;
        if (bad != 0) $display("FAIL wd_hold bad_cycles=%0d want=0", bad);
        else passed++;
        #1;
        total++;
        if (outs !== 5'b00000 || fsm_state !== 1'b1 || mem_timeout !== 1'b0)
            $display("FAIL wd_fire outs=%b fsm=%b to=%b want 00000/1/0", outs, fsm_state, mem_timeout);
        else passed++;
        @(posedge clk); #1;
        mem_req = 1'b0;
        #1;
        total++;
        if (mem_timeout !== 1'b1 || fsm_state !== 1'b0 || stall_count !== 16'd71)
            $display("FAIL wd_after to=%b fsm=%b cnt=%0d want 1/0/71", mem_timeout, fsm_state, stall_count);
        else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (mem_timeout !== 1'b1) $display("FAIL wd_sticky to=%b want=1", mem_timeout);
        else passed++;
    endtask

    task automatic test_saturation();
        @(posedge clk); #1;
        ex_mem_read = 1'b1; ex_rt = 16'd9; id_rs = 16'd9; id_uses_rs = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        total++;
        if (stall_count !== 16'hFFFF) $display("FAIL sat_value cnt=%h want=ffff", stall_count);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stall_count !== 16'hFFFF || pc_freeze !== 1'b1)
            $display("FAIL sat_hold cnt=%h pc=%b want ffff/1", stall_count, pc_freeze);
        else passed++;
        clear_inputs();
        #2 rest = 1'b0;
        #1;
        total++;
        if (stall_count !== 16'd0 || mem_timeout !== 1'b0)
            $display("FAIL sat_reset cnt=%h to=%b want 0/0", stall_count, mem_timeout);
        else passed++;
        @(negedge clk) rest = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_watchdog();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
